jk_bank_scheduler: RTL and testbench

Round-robin scheduler that shares one WIDTH-bit bank of JK flip-flops between NREQ requesters. Each requester posts a bank command (hold, reset, set, toggle) with a bit mask. The scheduler arbitrates, drives the bank's J/K inputs for exactly one clock, then reads the bank back and checks the result. It sits between the requesting logic and the JK bank, and it is the only driver of the bank's J/K inputs.

---
 rtl/jk_bank_scheduler_if.sv | 29 ++
 rtl/jk_bank_scheduler.sv | 174 +++++++++++++++++
 tb/tb_jk_bank_scheduler.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_scheduler_if.sv
// Requester and JK-bank connections of jk_bank_scheduler; the slave modport is the scheduler side.
interface jk_bank_scheduler_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned CNTW = 8;

    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     cmd;
    logic [WIDTH*NREQ-1:0] mask;
    logic [WIDTH-1:0]      q_i;
    logic [WIDTH-1:0]      j_o;
    logic [WIDTH-1:0]      k_o;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic [CNTW-1:0]       err_cnt;
    logic                  busy;

    modport master (
        output req, cmd, mask, q_i,
        input  j_o, k_o, gnt, done, err, err_cnt, busy
    );

    modport slave (
        input  req, cmd, mask, q_i,
        output j_o, k_o, gnt, done, err, err_cnt, busy
    );
endinterface

// File: rtl/jk_bank_scheduler.sv
// Round-robin scheduler that owns the J/K drive of a shared JK bank: one-cycle issue,
// then a one-cycle readback check against the value the command should have produced.
module jk_bank_scheduler #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    jk_bank_scheduler_if.slave bus
);
    localparam int unsigned IDXW = $clog2(NREQ);
    localparam int unsigned PW   = IDXW + 1;
    localparam int unsigned CNTW = 8;

    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_SET    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [IDXW-1:0]   win_q, win_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [WIDTH-1:0]  qprev_q, qprev_d;
    logic [WIDTH-1:0]  j_q, j_d;
    logic [WIDTH-1:0]  k_q, k_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic              any_req_c;
    logic              found_c;
    logic [PW-1:0]     pos_c;
    logic [PW-1:0]     nxt_c;
    logic [IDXW-1:0]   arb_idx_c;
    logic [IDXW-1:0]   rr_next_c;
    logic [1:0]        arb_cmd_c;
    logic [WIDTH-1:0]  arb_mask_c;
    logic [WIDTH-1:0]  exp_c;
    logic              err_c;
    logic              grant_c;

    // Rotating priority: first set req at or after rr_q, wrapping modulo NREQ.
    always_comb begin
        any_req_c  = |bus.req;
        found_c    = 1'b0;
        pos_c      = '0;
        arb_idx_c  = '0;
        arb_cmd_c  = CMD_HOLD;
        arb_mask_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            pos_c = PW'(rr_q) + PW'(i);
            if (pos_c >= PW'(NREQ)) pos_c = pos_c - PW'(NREQ);
            for (int j = 0; j < NREQ; j++) begin
                if (!found_c && pos_c == PW'(j) && bus.req[j]) begin
                    found_c   = 1'b1;
                    arb_idx_c = IDXW'(j);
                end
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (arb_idx_c == IDXW'(j)) begin
                arb_cmd_c  = bus.cmd[2*j +: 2];
                arb_mask_c = bus.mask[WIDTH*j +: WIDTH];
            end
        end
        nxt_c     = PW'(arb_idx_c) + PW'(1);
        rr_next_c = (nxt_c >= PW'(NREQ)) ? '0 : IDXW'(nxt_c);
    end

    // Value the bank should hold after the latched command acted on the snapshot.
    always_comb begin
        unique case (cmd_q)
            CMD_HOLD:  exp_c = qprev_q;
            CMD_RESET: exp_c = qprev_q & ~mask_q;
            CMD_SET:   exp_c = qprev_q | mask_q;
            default:   exp_c = qprev_q ^ mask_q;
        endcase
        err_c = (state_q == ST_CHECK) && (bus.q_i != exp_c);
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        win_d   = win_q;
        cmd_d   = cmd_q;
        mask_d  = mask_q;
        qprev_d = qprev_q;
        j_d     = '0;
        k_d     = '0;
        gnt_d   = '0;
        done_d  = '0;
        cnt_d   = cnt_q;
        grant_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                grant_c = any_req_c;
            end
            ST_ISSUE: begin
                qprev_d = bus.q_i;
                done_d  = NREQ'(1) << win_q;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (err_c && cnt_q != '1) cnt_d = cnt_q + CNTW'(1);
                grant_c = any_req_c;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // J drives set, K drives reset; both together toggle.
        if (grant_c) begin
            state_d = ST_ISSUE;
            win_d   = arb_idx_c;
            cmd_d   = arb_cmd_c;
            mask_d  = arb_mask_c;
            rr_d    = rr_next_c;
            gnt_d   = NREQ'(1) << arb_idx_c;
            j_d     = arb_mask_c & {WIDTH{arb_cmd_c[1]}};
            k_d     = arb_mask_c & {WIDTH{arb_cmd_c[0]}};
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= '0;
            win_q   <= '0;
            cmd_q   <= CMD_HOLD;
            mask_q  <= '0;
            qprev_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            win_q   <= win_d;
            cmd_q   <= cmd_d;
            mask_q  <= mask_d;
            qprev_q <= qprev_d;
            j_q     <= j_d;
            k_q     <= k_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.j_o     = j_q;
    assign bus.k_o     = k_q;
    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.err     = err_c;
    assign bus.err_cnt = cnt_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_jk_bank_scheduler.sv
// Bench for jk_bank_scheduler: requester drivers, a JK bank model, and a scoreboard monitor
// that predicts grant order, J/K drive, readback result and error count.
module tb_jk_bank_scheduler;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] RST  = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] TOG  = 2'b11;

    logic clk = 1'b0;
    logic rst_n;

    jk_bank_scheduler_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    jk_bank_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // JK bank: Q+ = J & ~Q | ~K & Q per bit; can be loaded or told to ignore J/K.
    logic [WIDTH-1:0] bank = '0;
    logic             ignore_jk = 1'b0;
    logic             load_en = 1'b0;
    logic [WIDTH-1:0] load_val = '0;

    always @(posedge clk) begin
        if (load_en) bank <= load_val;
        else if (!ignore_jk) bank <= (bus.j_o & ~bank) | (~bus.k_o & bank);
    end

    assign bus.q_i = bank;

    // Requester state, written only by the stimulus process.
    bit               pend   [NREQ];
    logic [1:0]       pcmd   [NREQ];
    logic [WIDTH-1:0] pmask  [NREQ];
    bit               sticky [NREQ];
    bit               rnd_mode = 1'b0;

    // Scoreboard state, written only by the monitor process.
    typedef struct {
        int               idx;
        logic [WIDTH-1:0] q;
        logic             e;
    } exp_t;

    exp_t expq[$];
    int   nvec  = 0;
    int   nerr  = 0;
    int   mptr  = 0;
    int   prevw = -1;
    int   cnt_m = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, want);
        end
    endfunction

    function automatic logic [WIDTH-1:0] apply_cmd(logic [1:0] c, logic [WIDTH-1:0] q,
                                                   logic [WIDTH-1:0] m);
        case (c)
            HOLD:    return q;
            RST:     return q & ~m;
            SET:     return q | m;
            default: return q ^ m;
        endcase
    endfunction

    function automatic int predict();
        for (int n = 0; n < NREQ; n++) begin
            int idx;
            idx = (mptr + n) % NREQ;
            if (pend[idx]) return idx;
        end
        return -1;
    endfunction

    // Monitor: samples 1 ns after each rising edge, or just after reset falls.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                chk("rst_gnt", 32'(bus.gnt), 0);
                chk("rst_done", 32'(bus.done), 0);
                chk("rst_err", 32'(bus.err), 0);
                chk("rst_err_cnt", 32'(bus.err_cnt), 0);
                chk("rst_busy", 32'(bus.busy), 0);
                chk("rst_j", 32'(bus.j_o), 0);
                chk("rst_k", 32'(bus.k_o), 0);
                expq.delete();
                mptr  = 0;
                prevw = -1;
                cnt_m = 0;
            end else begin
                chk("err_cnt", 32'(bus.err_cnt), 32'(cnt_m));
                if (prevw >= 0) begin
                    exp_t e;
                    chk("check_gnt", 32'(bus.gnt), 0);
                    chk("check_done", 32'(bus.done), 32'(1) << prevw);
                    chk("check_busy", 32'(bus.busy), 1);
                    chk("check_j", 32'(bus.j_o), 0);
                    chk("check_k", 32'(bus.k_o), 0);
                    if (expq.size() == 0) begin
                        chk("scoreboard_empty", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("check_err", 32'(bus.err), 32'(e.e));
                        chk("bank_result", 32'(bank), 32'(e.q));
                        if (e.e && cnt_m < 255) cnt_m++;
                    end
                    prevw = -1;
                end else begin
                    int w;
                    chk("done_idle", 32'(bus.done), 0);
                    chk("err_idle", 32'(bus.err), 0);
                    w = predict();
                    if (w < 0) begin
                        chk("idle_gnt", 32'(bus.gnt), 0);
                        chk("idle_busy", 32'(bus.busy), 0);
                        chk("idle_j", 32'(bus.j_o), 0);
                        chk("idle_k", 32'(bus.k_o), 0);
                    end else begin
                        exp_t e;
                        logic [WIDTH-1:0] ej;
                        logic [WIDTH-1:0] ek;
                        logic [WIDTH-1:0] after;
                        case (pcmd[w])
                            HOLD:    begin ej = '0;       ek = '0;       end
                            RST:     begin ej = '0;       ek = pmask[w]; end
                            SET:     begin ej = pmask[w]; ek = '0;       end
                            default: begin ej = pmask[w]; ek = pmask[w]; end
                        endcase
                        chk("issue_gnt", 32'(bus.gnt), 32'(1) << w);
                        chk("issue_busy", 32'(bus.busy), 1);
                        chk("issue_j", 32'(bus.j_o), 32'(ej));
                        chk("issue_k", 32'(bus.k_o), 32'(ek));
                        after = apply_cmd(pcmd[w], bank, pmask[w]);
                        e.idx = w;
                        e.q   = ignore_jk ? bank : after;
                        e.e   = ignore_jk && (after != bank);
                        expq.push_back(e);
                        prevw = w;
                        mptr  = (w + 1) % NREQ;
                    end
                end
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]                 = pend[i];
            bus.cmd[2*i +: 2]          = pcmd[i];
            bus.mask[WIDTH*i +: WIDTH] = pmask[i];
        end
    endtask

    task automatic post(int i, logic [1:0] c, logic [WIDTH-1:0] m);
        pend[i]  = 1'b1;
        pcmd[i]  = c;
        pmask[i] = m;
        drive();
    endtask

    task automatic post_rand(int i);
        pend[i]  = 1'b1;
        pcmd[i]  = 2'($urandom_range(0, 3));
        pmask[i] = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
    endtask

    // One cycle of requester behaviour: a granted requester drops or re-posts.
    task automatic cyc();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (pend[i] && bus.gnt[i] === 1'b1) begin
                pend[i] = 1'b0;
                if (sticky[i]) pend[i] = 1'b1;
                else if (rnd_mode && $urandom_range(0, 2) == 0) post_rand(i);
            end else if (rnd_mode && !pend[i] && $urandom_range(0, 3) == 0) begin
                post_rand(i);
            end
        end
        drive();
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < NREQ; i++) if (pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_idle();
        for (int t = 0; t < 40; t++) begin
            cyc();
            if (!bus.busy && !any_pend()) break;
        end
    endtask

    task automatic load_bank(logic [WIDTH-1:0] v);
        cyc();
        load_val = v;
        load_en  = 1'b1;
        cyc();
        load_en  = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pend[i]   = 1'b0;
            pcmd[i]   = HOLD;
            pmask[i]  = '0;
            sticky[i] = 1'b0;
        end
        drive();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // SET 0x0F on a cleared bank
        load_bank(8'h00);
        post(0, SET, 8'h0F);
        wait_idle();

        // TOGGLE 0xA5 on an all-ones bank
        load_bank(8'hFF);
        post(0, TOG, 8'hA5);
        wait_idle();

        // Full contention from rr_ptr=0, requests re-posted on every grant
        reset_pulse();
        for (int i = 0; i < NREQ; i++) begin
            sticky[i] = 1'b1;
            post(i, HOLD, WIDTH'($urandom));
        end
        repeat (12) cyc();
        for (int i = 0; i < NREQ; i++) sticky[i] = 1'b0;
        wait_idle();

        // Bank ignores J/K: every SET 0x80 on a cleared bank is a readback error
        load_bank(8'h00);
        ignore_jk = 1'b1;
        for (int n = 0; n < 300; n++) begin
            post(0, SET, 8'h80);
            wait_idle();
        end
        ignore_jk = 1'b0;

        // Reset during ISSUE drops the transaction and rr_ptr returns to 0
        post(1, SET, 8'h01);
        wait_idle();
        post(2, SET, 8'h02);
        for (int t = 0; t < 10; t++) begin
            cyc();
            if (bus.gnt[2] === 1'b1) break;
        end
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        cyc();
        post(0, RST, 8'h01);
        post(3, SET, 8'h40);
        wait_idle();

        // rr_ptr=2 with req=0011: requester 0 first, then 1; includes HOLD with mask 0
        post(1, HOLD, 8'h00);
        wait_idle();
        post(0, TOG, 8'h3C);
        post(1, HOLD, 8'h00);
        wait_idle();

        // Randomized traffic
        rnd_mode = 1'b1;
        repeat (3000) cyc();
        rnd_mode = 1'b0;
        wait_idle();
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
